avalon_addr_bridge: RTL and testbench

Registered one-deep Avalon-MM bridge between the `mips_cpu_bus` master port and the simulation RAM slave in the integration bench. It translates CPU addresses in the window `BASE_ADDR..BASE_ADDR+SPAN-1` to zero-based slave offsets and forwards legal transfers. Out-of-range, misaligned or malformed requests are completed locally, so a bad access is reported with its address instead of corrupting RAM. It also counts transactions and slave stall cycles for bench logging.

---
 rtl/avalon_addr_bridge.sv | 134 +++++++++++++
 tb/tb_avalon_addr_bridge.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/avalon_addr_bridge.sv
// avalon_addr_bridge: registered one-deep Avalon-MM bridge from the CPU master
// port to the bench RAM slave. Addresses inside the BASE_ADDR window are
// rebased to zero and forwarded. Out-of-window, misaligned or malformed
// requests are completed locally and flagged. Transaction and slave stall
// counters are kept for bench logging.
module avalon_addr_bridge #(
  parameter logic [31:0] BASE_ADDR    = 32'hBFC00000,
  parameter logic [31:0] SPAN         = 32'h00010000,
  parameter logic [31:0] ERR_READDATA = 32'h00000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] m_address,
  input  logic        m_read,
  input  logic        m_write,
  input  logic [31:0] m_writedata,
  input  logic [3:0]  m_byteenable,
  output logic        m_waitrequest,
  output logic [31:0] m_readdata,
  output logic [31:0] s_address,
  output logic        s_read,
  output logic        s_write,
  output logic [31:0] s_writedata,
  output logic [3:0]  s_byteenable,
  input  logic        s_waitrequest,
  input  logic [31:0] s_readdata,
  output logic        range_error,
  output logic        proto_error,
  output logic [31:0] err_address,
  output logic [31:0] txn_count,
  output logic [15:0] stall_count
);

  typedef enum logic [1:0] {IDLE, FWD, RESP, ERR} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] off;
  logic        req;
  logic        bad_proto;
  logic        bad_range;
  logic        err_seen;
  logic [31:0] rdata_q;

  // Stall counter saturates rather than wrapping so long stalls stay visible.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Offset computed with 32-bit wrap: addresses below BASE_ADDR become huge
  // offsets and fall out of the window naturally.
  assign off       = m_address - BASE_ADDR;
  assign req       = m_read | m_write;
  assign bad_proto = m_read & m_write;
  assign bad_range = (off >= SPAN) || (m_address[1:0] != 2'b00);
  assign err_seen  = range_error | proto_error;

  // Master response is decoded from state; only the completion cycles release it.
  assign m_waitrequest = !((state == RESP) || (state == ERR));
  assign m_readdata    = (state == ERR) ? ERR_READDATA : rdata_q;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req) begin
          if (bad_proto || bad_range) state_nxt = ERR;
          else                        state_nxt = FWD;
        end
      end
      FWD:     if (!s_waitrequest) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      ERR:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Slave request registers, captured read data, error flags and counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      s_address    <= '0;
      s_read       <= 1'b0;
      s_write      <= 1'b0;
      s_writedata  <= '0;
      s_byteenable <= '0;
      rdata_q      <= '0;
      range_error  <= 1'b0;
      proto_error  <= 1'b0;
      err_address  <= '0;
      txn_count    <= '0;
      stall_count  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            if (bad_proto) begin
              proto_error <= 1'b1;
              if (!err_seen) err_address <= m_address;
            end else if (bad_range) begin
              range_error <= 1'b1;
              if (!err_seen) err_address <= m_address;
            end else begin
              s_address    <= off;
              s_read       <= m_read;
              s_write      <= m_write;
              s_writedata  <= m_writedata;
              s_byteenable <= m_byteenable;
            end
          end
        end
        FWD: begin
          if (s_waitrequest) begin
            stall_count <= sat_inc16(stall_count);
          end else begin
            if (s_read) rdata_q <= s_readdata;
            s_read  <= 1'b0;
            s_write <= 1'b0;
          end
        end
        RESP:    txn_count <= txn_count + 32'd1;
        ERR:     txn_count <= txn_count + 32'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_avalon_addr_bridge.sv
// Directed testbench for avalon_addr_bridge with hand-computed expectations.
module tb_avalon_addr_bridge;

  logic        clk;
  logic        reset;
  logic [31:0] m_address;
  logic        m_read;
  logic        m_write;
  logic [31:0] m_writedata;
  logic [3:0]  m_byteenable;
  logic        m_waitrequest;
  logic [31:0] m_readdata;
  logic [31:0] s_address;
  logic        s_read;
  logic        s_write;
  logic [31:0] s_writedata;
  logic [3:0]  s_byteenable;
  logic        s_waitrequest;
  logic [31:0] s_readdata;
  logic        range_error;
  logic        proto_error;
  logic [31:0] err_address;
  logic [31:0] txn_count;
  logic [15:0] stall_count;

  int n_total = 0;
  int n_bad   = 0;
  int s_act   = 0;
  int s_act_snap;

  avalon_addr_bridge dut (
    .clk           (clk),
    .reset         (reset),
    .m_address     (m_address),
    .m_read        (m_read),
    .m_write       (m_write),
    .m_writedata   (m_writedata),
    .m_byteenable  (m_byteenable),
    .m_waitrequest (m_waitrequest),
    .m_readdata    (m_readdata),
    .s_address     (s_address),
    .s_read        (s_read),
    .s_write       (s_write),
    .s_writedata   (s_writedata),
    .s_byteenable  (s_byteenable),
    .s_waitrequest (s_waitrequest),
    .s_readdata    (s_readdata),
    .range_error   (range_error),
    .proto_error   (proto_error),
    .err_address   (err_address),
    .txn_count     (txn_count),
    .stall_count   (stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count clock edges on which the slave sees an active request.
  always @(posedge clk) if (s_read || s_write) s_act <= s_act + 1;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; m_address = '0; m_read = 0; m_write = 0;
    m_writedata = '0; m_byteenable = '0; s_waitrequest = 0; s_readdata = '0;
    repeat (2) @(negedge clk);
    chk_eq("rst_mwait", m_waitrequest, 1);
    chk_eq("rst_sread", s_read, 0);
    chk_eq("rst_txn", txn_count, 0);
    chk_eq("rst_rerr", range_error, 0);
    reset = 1'b0;
    @(negedge clk);

    // Read, zero-wait slave
    s_readdata = 32'hDEADBEEF; s_waitrequest = 0;
    m_address = 32'hBFC00010; m_read = 1;
    @(negedge clk);
    chk_eq("rd_saddr", s_address, 32'h10);
    chk_eq("rd_sread", s_read, 1);
    chk_eq("rd_c1_mwait", m_waitrequest, 1);
    @(negedge clk);
    chk_eq("rd_c2_mwait", m_waitrequest, 0);
    chk_eq("rd_data", m_readdata, 32'hDEADBEEF);
    chk_eq("rd_c2_sread", s_read, 0);
    m_read = 0;
    @(negedge clk);
    chk_eq("rd_txn", txn_count, 1);
    chk_eq("rd_idle_mwait", m_waitrequest, 1);

    // Write at top of window, 3 stall cycles
    m_address = 32'hBFC0FFFC; m_write = 1; m_writedata = 32'h12345678;
    m_byteenable = 4'b0011; s_waitrequest = 1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      chk_eq($sformatf("wr_swrite_c%0d", c), s_write, 1);
      chk_eq($sformatf("wr_saddr_c%0d", c), s_address, 32'hFFFC);
      chk_eq($sformatf("wr_wdata_c%0d", c), s_writedata, 32'h12345678);
      chk_eq($sformatf("wr_be_c%0d", c), s_byteenable, 32'h3);
      chk_eq($sformatf("wr_mwait_c%0d", c), m_waitrequest, 1);
      if (c == 4) s_waitrequest = 0;
    end
    @(negedge clk);
    chk_eq("wr_c5_mwait", m_waitrequest, 0);
    chk_eq("wr_stall", stall_count, 3);
    chk_eq("wr_c5_swrite", s_write, 0);
    m_write = 0;
    @(negedge clk);
    chk_eq("wr_txn", txn_count, 2);

    // Out-of-window read, then further errors
    s_act_snap = s_act;
    m_address = 32'hBFC10000; m_read = 1;
    @(negedge clk);
    chk_eq("oor_mwait", m_waitrequest, 0);
    chk_eq("oor_rdata", m_readdata, 32'h0);
    chk_eq("oor_rerr", range_error, 1);
    chk_eq("oor_perr", proto_error, 0);
    chk_eq("oor_eaddr", err_address, 32'hBFC10000);
    chk_eq("oor_sread", s_read, 0);
    m_read = 0;
    @(negedge clk);
    chk_eq("oor_txn", txn_count, 3);
    m_address = 32'h0; m_read = 1;
    @(negedge clk);
    chk_eq("zero_mwait", m_waitrequest, 0);
    chk_eq("zero_eaddr", err_address, 32'hBFC10000);
    m_read = 0;
    @(negedge clk);
    m_address = 32'hBFBFFFFC; m_read = 1;
    @(negedge clk);
    chk_eq("below_mwait", m_waitrequest, 0);
    m_read = 0;
    @(negedge clk);
    chk_eq("err_txn", txn_count, 5);
    chk_eq("err_slave_idle", s_act - s_act_snap, 0);

    // Fresh reset, misaligned then protocol error
    reset = 1; @(negedge clk); reset = 0;
    chk_eq("rst2_rerr", range_error, 0);
    s_act_snap = s_act;
    m_address = 32'hBFC00002; m_read = 1;
    @(negedge clk);
    chk_eq("mis_mwait", m_waitrequest, 0);
    chk_eq("mis_rerr", range_error, 1);
    chk_eq("mis_perr", proto_error, 0);
    chk_eq("mis_eaddr", err_address, 32'hBFC00002);
    m_read = 0;
    @(negedge clk);
    m_address = 32'hBFC00000; m_read = 1; m_write = 1; m_writedata = 32'hAAAA5555;
    @(negedge clk);
    chk_eq("proto_mwait", m_waitrequest, 0);
    chk_eq("proto_perr", proto_error, 1);
    chk_eq("proto_rerr", range_error, 1);
    chk_eq("proto_eaddr", err_address, 32'hBFC00002);
    chk_eq("proto_swrite", s_write, 0);
    m_read = 0; m_write = 0;
    @(negedge clk);
    chk_eq("proto_txn", txn_count, 2);
    chk_eq("proto_slave_idle", s_act - s_act_snap, 0);

    // Reset while slave stalls in FWD
    s_waitrequest = 1; m_address = 32'hBFC00020; m_read = 1;
    @(negedge clk);
    chk_eq("rf_sread", s_read, 1);
    @(negedge clk);
    reset = 1; m_read = 0;
    @(negedge clk);
    chk_eq("rf_mwait", m_waitrequest, 1);
    chk_eq("rf_rdata", m_readdata, 0);
    chk_eq("rf_sread0", s_read, 0);
    chk_eq("rf_swrite0", s_write, 0);
    chk_eq("rf_saddr", s_address, 0);
    chk_eq("rf_wdata", s_writedata, 0);
    chk_eq("rf_be", s_byteenable, 0);
    chk_eq("rf_rerr", range_error, 0);
    chk_eq("rf_perr", proto_error, 0);
    chk_eq("rf_eaddr", err_address, 0);
    chk_eq("rf_txn", txn_count, 0);
    chk_eq("rf_stall", stall_count, 0);
    reset = 0; s_waitrequest = 0; s_readdata = 32'hCAFEF00D;
    m_address = 32'hBFC00020; m_read = 1;
    @(negedge clk);
    chk_eq("rf2_sread", s_read, 1);
    chk_eq("rf2_saddr", s_address, 32'h20);
    @(negedge clk);
    chk_eq("rf2_mwait", m_waitrequest, 0);
    chk_eq("rf2_rdata", m_readdata, 32'hCAFEF00D);
    m_read = 0;
    @(negedge clk);
    chk_eq("rf2_txn", txn_count, 1);
    chk_eq("rf2_stall", stall_count, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
